// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encoder_pkg
// Purpose  : Shared types, field constants and word packer for instr_encoder.
// Revision : 1.0
// ============================================================================
package encoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_EMIT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic       MEM_P   = 1'b1;
    localparam logic       MEM_U   = 1'b1;
    localparam logic       MEM_B   = 1'b0;
    localparam logic       MEM_W   = 1'b0;

    localparam int         ROT_W   = 4;

    // op2 carries the low 12 bits for DP and MEM; off carries the BR offset.
    function automatic logic [31:0] encode_word(
        input logic [1:0]  op,
        input logic [3:0]  cond,
        input logic [3:0]  cmd,
        input logic        s,
        input logic        i,
        input logic        load,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [11:0] op2,
        input logic [23:0] off
    );
        logic [31:0] w;
        w = 32'h0;
        case (op)
            OP_DP:   w = {cond, 2'b00, i, cmd, s, rn, rd, op2};
            OP_MEM:  w = {cond, 2'b01, 1'b0, MEM_P, MEM_U, MEM_B, MEM_W, load, rn, rd, op2};
            OP_BR:   w = {cond, 3'b101, load, off};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_imm_rot_check.sv
`default_nettype none
// ============================================================================
// Module   : imm_rot_check
// Purpose  : Tests whether imm rotated left by 2*r fits in the low 8 bits.
// Revision : 1.0
// ============================================================================
module imm_rot_check
    import encoder_pkg::*;
(
    input  logic [31:0]      imm,
    input  logic [ROT_W-1:0] r,
    output logic             hit,
    output logic [7:0]       imm8
);

    logic [4:0]  w_amt;
    logic [31:0] w_rol;

    assign w_amt = {r, 1'b0};
    // A 32-bit shift right by 32 yields zero, so r=0 degenerates to imm.
    assign w_rol = (imm << w_amt) | (imm >> (6'd32 - {1'b0, w_amt}));
    assign hit   = ~|w_rol[31:8];
    assign imm8  = w_rol[7:0];

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs field-level instructions into 32-bit words and writes them
//            to instruction memory at an auto-incrementing address.
// Revision : 1.0
// ============================================================================
module instr_encoder
    import encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_cmd,
    input  logic              in_s,
    input  logic              in_i,
    input  logic              in_load,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rm,
    input  logic [1:0]        in_sh,
    input  logic [4:0]        in_shamt,
    input  logic [31:0]       in_imm,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              err,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] C_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t             r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_full;
    logic               r_we;
    logic [ADDR_W-1:0]  r_waddr;
    logic [31:0]        r_wdata;
    logic               r_err;
    logic [ROT_W-1:0]   r_r;
    logic [3:0]         r_cond;
    logic [3:0]         r_cmd;
    logic               r_s;
    logic [3:0]         r_rn;
    logic [3:0]         r_rd;
    logic [31:0]        r_imm;

    logic               w_ready;
    logic               w_accept;
    logic               w_bad;
    logic               w_hit;
    logic [7:0]         w_imm8;
    logic [11:0]        w_op2_in;
    logic [31:0]        w_word_in;
    logic [31:0]        w_word_rot;

    assign w_ready  = (r_state == S_IDLE) && !r_full;
    assign w_accept = in_valid && w_ready && !clear;

    // BR offsets must sign-extend cleanly from bit 23.
    assign w_bad = (in_op == 2'b11)
                 || ((in_op == OP_MEM) && (|in_imm[31:12]))
                 || ((in_op == OP_BR) && !((&in_imm[31:23]) || !(|in_imm[31:23])));

    assign w_op2_in   = (in_op == OP_DP) ? {in_shamt, in_sh, 1'b0, in_rm} : in_imm[11:0];
    assign w_word_in  = encode_word(in_op, in_cond, in_cmd, in_s, 1'b0, in_load,
                                    in_rn, in_rd, w_op2_in, in_imm[23:0]);
    assign w_word_rot = encode_word(OP_DP, r_cond, r_cmd, r_s, 1'b1, 1'b0,
                                    r_rn, r_rd, {r_r, w_imm8}, 24'h0);

    imm_rot_check u_rot (
        .imm  (r_imm),
        .r    (r_r),
        .hit  (w_hit),
        .imm8 (w_imm8)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_r     <= '0;
            r_cond  <= '0;
            r_cmd   <= '0;
            r_s     <= 1'b0;
            r_rn    <= '0;
            r_rd    <= '0;
            r_imm   <= '0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_ptr   <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_cond <= in_cond;
                            r_cmd  <= in_cmd;
                            r_s    <= in_s;
                            r_rn   <= in_rn;
                            r_rd   <= in_rd;
                            r_imm  <= in_imm;
                            r_r    <= '0;
                            if (w_bad) begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end else if ((in_op == OP_DP) && in_i) begin
                                r_state <= S_ROT;
                            end else begin
                                r_state <= S_EMIT;
                                r_we    <= 1'b1;
                                r_waddr <= r_ptr;
                                r_wdata <= w_word_in;
                            end
                        end
                    end
                    S_ROT: begin
                        if (w_hit) begin
                            r_state <= S_EMIT;
                            r_we    <= 1'b1;
                            r_waddr <= r_ptr;
                            r_wdata <= w_word_rot;
                        end else if (r_r == 4'd15) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_r <= r_r + 4'd1;
                        end
                    end
                    S_EMIT: begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_count <= r_count + (ADDR_W+1)'(1);
                        r_full  <= (r_count == C_LAST);
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready = w_ready;
    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign err      = r_err;
    assign full     = r_full;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Scoreboard bench for instr_encoder with a 4-word memory.
// Revision : 1.0
// ============================================================================
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [3:0]    in_cond;
    logic [3:0]    in_cmd;
    logic          in_s;
    logic          in_i;
    logic          in_load;
    logic [3:0]    in_rn;
    logic [3:0]    in_rd;
    logic [3:0]    in_rm;
    logic [1:0]    in_sh;
    logic [4:0]    in_shamt;
    logic [31:0]   in_imm;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          err;
    logic          full;
    logic [AW:0]   count;

    typedef struct {
        logic          is_err;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_cond  (in_cond),
        .in_cmd   (in_cmd),
        .in_s     (in_s),
        .in_i     (in_i),
        .in_load  (in_load),
        .in_rn    (in_rn),
        .in_rd    (in_rd),
        .in_rm    (in_rm),
        .in_sh    (in_sh),
        .in_shamt (in_shamt),
        .in_imm   (in_imm),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .err      (err),
        .full     (full),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (we || err)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {30'b0, we, err}, 32'h0);
            end else begin
                e = q.pop_front();
                chk("err_strobe", {31'b0, err}, {31'b0, e.is_err});
                chk("we_strobe", {31'b0, we}, {31'b0, !e.is_err});
                chk("latency", cyc, e.cyc);
                if (!e.is_err) begin
                    chk("waddr", {30'b0, waddr}, {30'b0, e.addr});
                    chk("wdata", wdata, e.data);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [3:0] cond, input logic [3:0] cmd,
                         input logic s, input logic i, input logic load,
                         input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                         input logic [1:0] sh, input logic [4:0] shamt, input logic [31:0] imm);
        in_op = op; in_cond = cond; in_cmd = cmd; in_s = s; in_i = i; in_load = load;
        in_rn = rn; in_rd = rd; in_rm = rm; in_sh = sh; in_shamt = shamt; in_imm = imm;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] cond, input logic [3:0] cmd,
                         input logic s, input logic i, input logic load,
                         input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                         input logic [1:0] sh, input logic [4:0] shamt, input logic [31:0] imm,
                         input logic e_err, input logic [AW-1:0] e_addr,
                         input logic [31:0] e_data, input int lat);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", {31'b0, in_ready}, 32'h1);
        end else begin
            drive(op, cond, cmd, s, i, load, rn, rd, rm, sh, shamt, imm);
            in_valid = 1'b1;
            e.is_err = e_err;
            e.addr   = e_addr;
            e.data   = e_data;
            e.cyc    = cyc + lat;
            q.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'h0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", {31'b0, we}, 32'h0);
        chk("rst_waddr", {30'b0, waddr}, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_full", {31'b0, full}, 32'h0);
        chk("rst_count", {29'b0, count}, 32'h0);
        chk("rst_ready", {31'b0, in_ready}, 32'h1);
        reset = 1'b0;

        // Immediate forms through the rotation search
        issue(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 2'b00, 5'd0,
              32'h0000_00FF, 1'b0, 2'd0, 32'hE282_10FF, 2);
        issue(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 2'b00, 5'd0,
              32'hFF00_0000, 1'b0, 2'd1, 32'hE282_14FF, 6);
        issue(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 2'b00, 5'd0,
              32'h0000_0101, 1'b1, 2'd0, 32'h0, 17);
        @(negedge clk);
        chk("rot_busy_ready", {31'b0, in_ready}, 32'h0);
        drain();
        chk("err_count_kept", {29'b0, count}, 32'h2);
        chk("err_ready_back", {31'b0, in_ready}, 32'h1);

        do_clear();
        // Register, MEM and BR forms, then the direct error paths
        issue(2'b00, 4'hE, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 4'd2, 2'b00, 5'd3,
              32'h0, 1'b0, 2'd0, 32'hE051_0182, 1);
        issue(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 4'd0, 2'b00, 5'd0,
              32'h0000_0008, 1'b0, 2'd1, 32'hE590_3008, 1);
        issue(2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 5'd0,
              32'hFFFF_FFFE, 1'b0, 2'd2, 32'h0AFF_FFFE, 1);
        issue(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd3, 4'd0, 2'b00, 5'd0,
              32'h0000_1000, 1'b1, 2'd0, 32'h0, 1);
        issue(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 5'd0,
              32'h0080_0000, 1'b1, 2'd0, 32'h0, 1);
        issue(2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 2'b00, 5'd0,
              32'h0, 1'b1, 2'd0, 32'h0, 1);
        drain();
        chk("wdata_hold", wdata, 32'h0AFF_FFFE);
        chk("count_3", {29'b0, count}, 32'h3);
        issue(2'b00, 4'hE, 4'b1100, 1'b0, 1'b0, 1'b0, 4'd5, 4'd4, 4'd6, 2'b00, 5'd0,
              32'h0, 1'b0, 2'd3, 32'hE185_4006, 1);
        drain();
        chk("full_set", {31'b0, full}, 32'h1);
        chk("full_count", {29'b0, count}, 32'h4);
        chk("full_ready", {31'b0, in_ready}, 32'h0);

        // A request while full must be ignored; the monitor flags any strobe
        drive(2'b00, 4'hE, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 2'b00, 5'd0, 32'h0);
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("full_ignored_count", {29'b0, count}, 32'h4);

        do_clear();
        @(negedge clk);
        chk("clr_full", {31'b0, full}, 32'h0);
        chk("clr_count", {29'b0, count}, 32'h0);
        chk("clr_ready", {31'b0, in_ready}, 32'h1);
        issue(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 2'b00, 5'd0,
              32'h0000_00FF, 1'b0, 2'd0, 32'hE282_10FF, 2);
        drain();
        chk("clr_wrap_count", {29'b0, count}, 32'h1);

        // Asynchronous reset in the middle of a rotation search
        @(negedge clk);
        drive(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 4'd0, 2'b00, 5'd0, 32'h0000_0101);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_we", {31'b0, we}, 32'h0);
        chk("arst_count", {29'b0, count}, 32'h0);
        chk("arst_ready", {31'b0, in_ready}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("arst_no_write", {29'b0, count}, 32'h0);
        issue(2'b01, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 2'b00, 5'd0,
              32'h0000_0FFF, 1'b0, 2'd0, 32'hE581_2FFF, 1);
        drain();
        chk("queue_empty", q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
